// File: rtl/lexington_pkg.sv
// Shared definitions for the Lexington RV32 load/store path.
//   lsu_op_t       : load/store operation encoding carried from decode/ALU
//   EXC_*          : mcause codes reported by the LSU
//   op_is_store()  : classifies an operation as a store
package lexington_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } lsu_op_t;

    localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;

    function automatic logic op_is_store(input lsu_op_t op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   op, addr    : operation and effective address being checked/steered
//   wdata       : store source data (rs2)
//   rdata       : raw word returned by the data bus
//   misaligned  : halfword with addr[0]=1 or word with addr[1:0]!=0
//   be          : byte enables for the bus access
//   wdata_lane  : store data replicated across byte lanes
//   rdata_ext   : selected load lane, sign/zero-extended to 32 bits
module lsu_align
    import lexington_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{addr[1:0], 3'b000} +: 8];
        half_sel   = addr[1] ? rdata[31:16] : rdata[15:0];
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata_lane = '0;
        rdata_ext  = '0;
        case (op)
            LSU_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: rdata_ext = {24'd0, byte_sel};
            LSU_LH: begin
                misaligned = addr[0];
                rdata_ext  = {{16{half_sel[15]}}, half_sel};
            end
            LSU_LHU: begin
                misaligned = addr[0];
                rdata_ext  = {16'd0, half_sel};
            end
            LSU_LW: begin
                misaligned = |addr[1:0];
                rdata_ext  = rdata;
            end
            LSU_SB: begin
                be         = 4'b0001 << addr[1:0];
                wdata_lane = {4{wdata[7:0]}};
            end
            LSU_SH: begin
                misaligned = addr[0];
                be         = 4'b0011 << addr[1:0];
                wdata_lane = {2{wdata[15:0]}};
            end
            LSU_SW: begin
                misaligned = |addr[1:0];
                wdata_lane = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-bus transaction at a time.
//   clk, rst_n                : core clock, synchronous active-low reset
//   req_*                     : request from the ALU stage (req_ready high only in IDLE)
//   rsp_*                     : one-cycle response to writeback/trap logic
//   bus_req/we/addr/be/wdata  : data-bus request, held stable until bus_gnt
//   bus_gnt/rvalid/rdata/err  : data-bus handshake and response
// TIMEOUT_CYCLES bounds the time spent in REQ+WAIT (0 disables the timeout).
module lsu
    import lexington_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  lsu_op_t     req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [3:0]  rsp_cause,
    output logic [31:0] rsp_badaddr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    lsu_op_t     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        exc_q, exc_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] cnt_q, cnt_d;

    lsu_op_t     al_op;
    logic [31:0] al_addr;
    logic        al_misaligned;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        store;
    logic        timeout_hit;

    // One aligner serves both the IDLE misalignment check (live request)
    // and the REQ/WAIT steering (latched request).
    assign al_op   = (state_q == S_IDLE) ? req_op   : op_q;
    assign al_addr = (state_q == S_IDLE) ? req_addr : addr_q;

    lsu_align u_align (
        .op         (al_op),
        .addr       (al_addr),
        .wdata      (wdata_q),
        .rdata      (bus_rdata),
        .misaligned (al_misaligned),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        exc_d       = exc_q;
        cause_d     = cause_q;
        cnt_d       = '0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_exc     = 1'b0;
        rsp_cause   = '0;
        rsp_badaddr = '0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_be      = '0;
        bus_wdata   = '0;

        store       = op_is_store(op_q);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LAST);

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && (req_op != LSU_NONE)) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    if (al_misaligned) begin
                        exc_d   = 1'b1;
                        cause_d = op_is_store(req_op) ? EXC_STORE_MISALIGNED
                                                      : EXC_LOAD_MISALIGNED;
                        state_d = S_RESP;
                    end else begin
                        exc_d   = 1'b0;
                        cause_d = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                bus_req   = 1'b1;
                bus_we    = store;
                bus_addr  = {addr_q[31:2], 2'b00};
                bus_be    = al_be;
                bus_wdata = store ? al_wdata : '0;
                cnt_d     = cnt_q + 32'd1;
                if (bus_gnt) begin
                    state_d = S_WAIT;
                end else if (timeout_hit) begin
                    exc_d   = 1'b1;
                    cause_d = store ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (bus_rvalid) begin
                    state_d = S_RESP;
                    if (bus_err) begin
                        exc_d   = 1'b1;
                        cause_d = store ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
                    end else begin
                        rdata_d = store ? '0 : al_rdata;
                    end
                end else if (timeout_hit) begin
                    exc_d   = 1'b1;
                    cause_d = store ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid   = 1'b1;
                rsp_rdata   = exc_q ? '0 : rdata_q;
                rsp_exc     = exc_q;
                rsp_cause   = exc_q ? cause_q : '0;
                rsp_badaddr = exc_q ? addr_q : '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= LSU_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
    import lexington_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    lsu_op_t     req_op = LSU_NONE;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [3:0]  rsp_cause;
    logic [31:0] rsp_badaddr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_exc     (rsp_exc),
        .rsp_cause   (rsp_cause),
        .rsp_badaddr (rsp_badaddr),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .bus_err     (bus_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] badaddr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("rsp_rdata",   rsp_rdata,   e.rdata);
                check_eq("rsp_exc",     rsp_exc,     e.exc);
                check_eq("rsp_cause",   rsp_cause,   e.cause);
                check_eq("rsp_badaddr", rsp_badaddr, e.badaddr);
            end
        end
    end

    // Drives one request and acts as the bus slave: grants after gnt_wait
    // stalled request cycles, returns rvalid the cycle after the grant.
    task automatic run_txn(
        input lsu_op_t     op,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input int          gnt_wait,
        input logic [31:0] rdata,
        input logic        err,
        input logic [31:0] exp_rdata,
        input logic        exp_exc,
        input logic [3:0]  exp_cause,
        input int          exp_lat,
        input logic        bus_on,
        input logic [31:0] exp_baddr,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_bwdata,
        input logic        exp_we,
        input logic        poke
    );
        exp_t e;
        int   lat = 0;
        int   req_cycles = 0;
        bit   granted = 0;
        bit   done = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        check_eq("ready_idle", req_ready, 32'd1);
        e.rdata   = exp_rdata;
        e.exc     = exp_exc;
        e.cause   = exp_cause;
        e.badaddr = exp_exc ? addr : 32'd0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = poke;
        if (poke) begin
            req_op   = LSU_LB;
            req_addr = 32'h0000_0F01;
        end
        for (int k = 1; k <= 30 && !done; k++) begin
            @(negedge clk);
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            bus_rdata  = '0;
            if (rsp_valid === 1'b1) begin
                lat       = k;
                done      = 1;
                req_valid = 1'b0;
            end else begin
                check_eq("ready_busy", req_ready, 32'd0);
                if (!bus_on) begin
                    check_eq("no_bus_req", bus_req, 32'd0);
                end else if (bus_req === 1'b1) begin
                    check_eq("bus_addr", bus_addr, exp_baddr);
                    check_eq("bus_be",   bus_be,   exp_be);
                    check_eq("bus_we",   bus_we,   exp_we);
                    if (exp_we) check_eq("bus_wdata", bus_wdata, exp_bwdata);
                    if (req_cycles == gnt_wait) begin
                        bus_gnt = 1'b1;
                        granted = 1;
                    end
                    req_cycles++;
                end else if (granted) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdata;
                    bus_err    = err;
                end
            end
        end
        check_eq("latency", lat, exp_lat);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready",   req_ready, 32'd1);
        check_eq("rst_rsp",     rsp_valid, 32'd0);
        check_eq("rst_bus_req", bus_req,   32'd0);
        check_eq("rst_bus_be",  bus_be,    32'd0);
        check_eq("rst_bus_adr", bus_addr,  32'd0);
        check_eq("rst_rdata",   rsp_rdata, 32'd0);
        rst_n = 1'b1;

        // LSU_NONE is ignored: stays ready, no bus, no response
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = LSU_NONE; req_addr = 32'h100;
        repeat (2) begin
            @(negedge clk);
            check_eq("none_ready", req_ready, 32'd1);
            check_eq("none_bus",   bus_req,   32'd0);
        end
        req_valid = 1'b0;

        // Loads, zero-wait bus
        run_txn(LSU_LW,  32'h100, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 3, 1, 32'h100, 4'hF, 0, 0, 0);
        run_txn(LSU_LB,  32'h103, 0, 0, 32'h80112233, 0, 32'hFFFFFF80, 0, 0, 3, 1, 32'h100, 4'hF, 0, 0, 0);
        run_txn(LSU_LBU, 32'h103, 0, 0, 32'h80112233, 0, 32'h00000080, 0, 0, 3, 1, 32'h100, 4'hF, 0, 0, 0);
        run_txn(LSU_LHU, 32'h102, 0, 0, 32'h80112233, 0, 32'h00008011, 0, 0, 3, 1, 32'h100, 4'hF, 0, 0, 0);
        run_txn(LSU_LH,  32'h100, 0, 0, 32'h12348765, 0, 32'hFFFF8765, 0, 0, 3, 1, 32'h100, 4'hF, 0, 0, 0);
        run_txn(LSU_LB,  32'h101, 0, 0, 32'h00007F00, 0, 32'h0000007F, 0, 0, 3, 1, 32'h100, 4'hF, 0, 0, 0);

        // Stores: lane steering, rdata forced to 0
        run_txn(LSU_SH, 32'h206, 32'h1234ABCD, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 3, 1, 32'h204, 4'b1100, 32'hABCDABCD, 1, 0);
        run_txn(LSU_SB, 32'h201, 32'h00000055, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 3, 1, 32'h200, 4'b0010, 32'h55555555, 1, 0);
        run_txn(LSU_SW, 32'h20C, 32'hA5A55A5A, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 3, 1, 32'h20C, 4'b1111, 32'hA5A55A5A, 1, 0);

        // Misaligned: no bus activity, response in cycle 1
        run_txn(LSU_LW, 32'h101, 0, 0, 0, 0, 0, 1, EXC_LOAD_MISALIGNED,  1, 0, 0, 0, 0, 0, 0);
        run_txn(LSU_SH, 32'h003, 0, 0, 0, 0, 0, 1, EXC_STORE_MISALIGNED, 1, 0, 0, 0, 0, 0, 0);
        run_txn(LSU_LH, 32'h001, 0, 0, 0, 0, 0, 1, EXC_LOAD_MISALIGNED,  1, 0, 0, 0, 0, 0, 0);
        run_txn(LSU_SW, 32'h002, 0, 0, 0, 0, 0, 1, EXC_STORE_MISALIGNED, 1, 0, 0, 0, 0, 0, 0);

        // Grant held off 3 cycles (grant lands on the last counter value),
        // second request held during the stall must be ignored
        run_txn(LSU_LW, 32'h300, 0, 3, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 0, 6, 1, 32'h300, 4'hF, 0, 0, 1);

        // Bus errors
        run_txn(LSU_SW, 32'h400, 32'h11112222, 0, 32'h0, 1, 0, 1, EXC_STORE_FAULT, 3, 1, 32'h400, 4'hF, 32'h11112222, 1, 0);
        run_txn(LSU_LW, 32'h404, 0, 0, 32'h12345678, 1, 0, 1, EXC_LOAD_FAULT, 3, 1, 32'h404, 4'hF, 0, 0, 0);

        // Timeout: grant never comes
        run_txn(LSU_LW, 32'h500, 0, 100, 0, 0, 0, 1, EXC_LOAD_FAULT, 5, 1, 32'h500, 4'hF, 0, 0, 0);
        // Late rvalid while idle produces nothing
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h99999999;
        @(negedge clk);
        bus_rvalid = 1'b0; bus_rdata = '0;
        check_eq("late_rvalid_rsp", rsp_valid, 32'd0);
        @(negedge clk);
        check_eq("late_rvalid_rsp2", rsp_valid, 32'd0);
        check_eq("late_rvalid_rdy",  req_ready, 32'd1);

        // Reset while in WAIT abandons the transaction
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = LSU_LW; req_addr = 32'h600;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rstw_bus_req", bus_req, 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        check_eq("rstw_wait_req", bus_req, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rstw_rsp",   rsp_valid, 32'd0);
        check_eq("rstw_ready", req_ready, 32'd1);
        check_eq("rstw_bus",   bus_req,   32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h77777777;
        @(negedge clk);
        bus_rvalid = 1'b0;
        check_eq("rstw_rsp2", rsp_valid, 32'd0);

        repeat (4) @(negedge clk);
        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the Lexington RV32 core.
- Takes the ALU-computed effective address plus a load/store op, runs one data-bus transaction, and returns load data or an exception to writeback/trap logic.
- Handles byte-lane steering, sign/zero extension, misalignment detection, bus errors and a bus timeout.
- One transaction in flight at a time.

Parameters:
- TIMEOUT_CYCLES, default 255: cycles allowed in REQ+WAIT before an access fault. 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  1  request present
- req_op  in  lsu_op_t (4)  LSU_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store source (rs2)
- req_ready  out  1  high only in IDLE
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and exceptions
- rsp_exc  out  1  exception flag, qualified by rsp_valid
- rsp_cause  out  4  mcause code: 4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault
- rsp_badaddr  out  32  faulting address (req_addr); 0 when no exception
- bus_req  out  1  bus request
- bus_we  out  1  write enable
- bus_addr  out  32  word-aligned address, [1:0]=0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response (load data or store ack)
- bus_rdata  in  32  read data
- bus_err  in  1  error, qualified by bus_rvalid

Behaviour:
- Reset: when rst_n is low at a clk edge, state goes to IDLE. req_ready=1; all other outputs 0; timeout counter 0. Reset mid-transaction abandons it with no response.
- FSM states IDLE, REQ, WAIT, RESP:
  - IDLE: accept on req_valid & req_ready; latch op/addr/wdata. LSU_NONE is ignored and the FSM stays in IDLE. A misaligned request (halfword with addr[0]=1, or word with addr[1:0]!=0) goes to RESP with the misaligned cause and no bus activity. Otherwise go to REQ.
  - REQ: bus_req=1 and bus outputs held stable. On bus_gnt, go to WAIT. bus_rvalid is ignored in REQ.
  - WAIT: bus_req=0. On bus_rvalid, register the result and go to RESP. If bus_err=1, the result is a fault (cause 5 for loads, 7 for stores).
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Timeout: the counter increments each cycle in REQ or WAIT and clears in IDLE. When count==TIMEOUT_CYCLES-1 with no gnt/rvalid that cycle, raise a fault and go to RESP. A bus_rvalid arriving later in IDLE is ignored.
- Latency, counted from the accept cycle = 0:
  - Zero-wait bus: gnt in cycle 1, rvalid in cycle 2, rsp_valid in cycle 3.
  - Misaligned: rsp_valid in cycle 1.
- Store steering:
  - SB: wdata = 4 copies of byte [7:0]; be = 0001 << addr[1:0].
  - SH: wdata = 2 copies of [15:0]; be = 0011 << addr[1:0].
  - SW: be = 1111.
  - Loads: be = 1111, bus_we=0.
- Load extraction:
  - LB/LBU select byte lane addr[1:0].
  - LH/LHU select halfword addr[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.

Decomposition:
- lexington package:
  - lsu_op_t enum.
  - Exception cause constants EXC_LOAD_MISALIGNED=4, EXC_LOAD_FAULT=5, EXC_STORE_MISALIGNED=6, EXC_STORE_FAULT=7.
- Sub-module lsu_align: purely combinational misalignment check, be/wdata generation and load extraction. The lsu module holds the FSM and timeout counter.

Test Plan:
- LW addr 0x100, bus_rdata 0xDEADBEEF, zero-wait bus -> rsp_valid in cycle 3, rsp_rdata=0xDEADBEEF, rsp_exc=0, bus_addr=0x100, be=1111.
- LB addr 0x103, rdata 0x80112233 -> rsp_rdata=0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x00008011.
- SH addr 0x206, wdata 0x1234ABCD -> bus_we=1, bus_addr=0x204, be=1100, bus_wdata=0xABCDABCD; rsp_valid after rvalid with rdata=0.
- LW addr 0x101 -> no bus_req, rsp in cycle 1 with exc=1, cause=4, badaddr=0x101. SH addr 0x3 -> cause=6.
- bus_gnt held low 3 cycles then granted; req_ready low throughout and bus outputs stable; a second req_valid is not accepted until after RESP. Separately, rvalid with bus_err on a SW -> cause=7.
- TIMEOUT_CYCLES=4, gnt never asserted -> rsp_valid with cause 5 (load) four cycles after entering REQ. A late rvalid in IDLE produces no response. Separately, rst_n low while in WAIT -> IDLE next cycle, no rsp_valid.
